// File: rtl/gps_uart_rx.sv
// gps_uart_rx
// Receives 8N1 UART bytes (LSB first) from the GPS module and hands each
// correctly framed byte to the GPS byte buffer. data_valid is held high for
// VALID_CYCLES cycles, because the buffer synchronises it into another clock
// domain and detects a level rather than a single-cycle pulse.
//
// Ports:
//   clock_50mhz   in   single clock, all logic on its rising edge
//   reset_n       in   asynchronous active-low reset
//   rx            in   raw asynchronous UART line, idles high
//   data[7:0]     out  last correctly framed byte, held until the next one
//   data_valid    out  high for VALID_CYCLES cycles after each good byte
//   framing_error out  sticky, set on a bad stop bit, cleared by a good byte
//   busy          out  high whenever the receiver is not idle

module gps_uart_rx #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int VALID_CYCLES = 16
) (
   input  logic       clock_50mhz,
   input  logic       reset_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       framing_error,
   output logic       busy
);

   localparam int VW = $clog2(VALID_CYCLES + 1);
   localparam logic [12:0]   HALF_M1   = 13'(CLKS_PER_BIT / 2 - 1);
   localparam logic [12:0]   BIT_M1    = 13'(CLKS_PER_BIT - 1);
   localparam logic [VW-1:0] VALID_LD  = VW'(VALID_CYCLES);
   localparam logic [VW-1:0] VALID_ONE = VW'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t        state_q, state_d;
   logic          rx_meta_q, rx_meta_d;
   logic          rx_s_q, rx_s_d;
   logic          armed_q, armed_d;
   logic [12:0]   cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    data_q, data_d;
   logic          framing_error_q, framing_error_d;
   logic [VW-1:0] valid_cnt_q, valid_cnt_d;
   logic          busy_q, busy_d;

   // Next-state logic: synchroniser, arming, receive FSM and valid stretcher.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      bit_idx_d       = bit_idx_q;
      shreg_d         = shreg_q;
      data_d          = data_q;
      framing_error_d = framing_error_q;

      // Two-flop synchroniser; nothing else looks at rx directly.
      rx_meta_d = rx;
      rx_s_d    = rx_meta_q;

      // Once the line has been seen idle the receiver may accept a start bit.
      armed_d = armed_q | rx_s_q;

      // Stretcher runs on its own; a good stop bit below overrides the decrement.
      valid_cnt_d = (valid_cnt_q != '0) ? valid_cnt_q - VALID_ONE : '0;

      case (state_q)
         ST_IDLE: begin
            if (!rx_s_q && armed_q) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (cnt_q == HALF_M1) begin
               // Line back high at mid-start means it was only a glitch.
               if (rx_s_q) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_DATA;
                  cnt_d     = '0;
                  bit_idx_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 13'd1;
            end
         end
         ST_DATA: begin
            if (cnt_q == BIT_M1) begin
               shreg_d[bit_idx_q] = rx_s_q;
               cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 13'd1;
            end
         end
         ST_STOP: begin
            if (cnt_q == BIT_M1) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  data_d          = shreg_q;
                  framing_error_d = 1'b0;
                  valid_cnt_d     = VALID_LD;
                  state_d         = ST_IDLE;
               end else begin
                  framing_error_d = 1'b1;
                  state_d         = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q + 13'd1;
            end
         end
         ST_BREAK: begin
            // A low stop bit may be the start of a break; wait for idle.
            if (rx_s_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // All state registers, including the registered outputs.
   always_ff @(posedge clock_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q       <= 1'b1;
         rx_s_q          <= 1'b1;
         armed_q         <= 1'b0;
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         bit_idx_q       <= '0;
         shreg_q         <= '0;
         data_q          <= '0;
         framing_error_q <= 1'b0;
         valid_cnt_q     <= '0;
         busy_q          <= 1'b0;
      end else begin
         rx_meta_q       <= rx_meta_d;
         rx_s_q          <= rx_s_d;
         armed_q         <= armed_d;
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         bit_idx_q       <= bit_idx_d;
         shreg_q         <= shreg_d;
         data_q          <= data_d;
         framing_error_q <= framing_error_d;
         valid_cnt_q     <= valid_cnt_d;
         busy_q          <= busy_d;
      end
   end

   assign data          = data_q;
   assign data_valid    = (valid_cnt_q != '0);
   assign framing_error = framing_error_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_gps_uart_rx.sv
// tb_gps_uart_rx
// Directed bench for gps_uart_rx at 16 clocks per bit and a 4-cycle strobe.
// Inputs change on falling clock edges and outputs are sampled there too.
// A line driven low at the falling edge of cycle c0 is seen by the idle FSM
// at rising edge c0+3, so the stop bit is sampled at rising edge c0+155 and
// the strobe is first visible at the falling edge of cycle c0+155.

module tb_gps_uart_rx;

   localparam int CPB = 16;
   localparam int VC  = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       data_valid;
   logic       framing_error;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   gps_uart_rx #(
      .CLKS_PER_BIT(CPB),
      .VALID_CYCLES(VC)
   ) dut (
      .clock_50mhz  (clk),
      .reset_n      (reset_n),
      .rx           (rx),
      .data         (data),
      .data_valid   (data_valid),
      .framing_error(framing_error),
      .busy         (busy)
   );

   // Free-running clock and a cycle counter stepped on each rising edge.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe recorder: cycle and data at each rising strobe, and its length.
   int         strobe_cyc[$];
   logic [7:0] strobe_data[$];
   int         strobe_len[$];
   int         cur_len = 0;
   logic       prev_valid = 1'b0;

   always @(negedge clk) begin
      if (data_valid === 1'b1 && prev_valid !== 1'b1) begin
         strobe_cyc.push_back(cyc);
         strobe_data.push_back(data);
         cur_len = 1;
      end else if (data_valid === 1'b1) begin
         cur_len++;
      end else if (prev_valid === 1'b1) begin
         strobe_len.push_back(cur_len);
      end
      prev_valid = data_valid;
   end

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame; rx is left at the stop-bit level on return.
   task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_bit, output int c0);
      c0 = cyc;
      rx = 1'b0;
      repeat (cpb) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (cpb) @(negedge clk);
      end
      rx = stop_bit;
      repeat (cpb) @(negedge clk);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (data !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_data: got %h expected 00", data); end
      n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b expected 0", data_valid); end
      n_cmp++; if (framing_error !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ferr: got %b expected 0", framing_error); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL post_reset_busy: got %b expected 0", busy); end
      n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL post_reset_valid: got %b expected 0", data_valid); end
   endtask

   task automatic test_single_byte;
      int base;
      int c0;
      base = strobe_cyc.size();
      idle(10);
      send_byte(8'h24, CPB, 1'b1, c0);
      idle(10);
      n_cmp++; if (strobe_cyc.size() !== base + 1) begin n_bad++; $display("[TB] FAIL single_count: got %0d expected %0d", strobe_cyc.size() - base, 1); end
      n_cmp++; if (data !== 8'h24) begin n_bad++; $display("[TB] FAIL single_data: got %h expected 24", data); end
      n_cmp++; if (framing_error !== 1'b0) begin n_bad++; $display("[TB] FAIL single_ferr: got %b expected 0", framing_error); end
      if (strobe_cyc.size() > base && strobe_len.size() > base) begin
         n_cmp++; if (strobe_cyc[base] !== c0 + 155) begin n_bad++; $display("[TB] FAIL single_rise: got cycle %0d expected %0d", strobe_cyc[base], c0 + 155); end
         n_cmp++; if (strobe_len[base] !== VC) begin n_bad++; $display("[TB] FAIL single_len: got %0d expected %0d", strobe_len[base], VC); end
         n_cmp++; if (strobe_data[base] !== 8'h24) begin n_bad++; $display("[TB] FAIL single_strobe_data: got %h expected 24", strobe_data[base]); end
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] msg [5];
      int c [5];
      int base;
      msg = '{8'h47, 8'h50, 8'h47, 8'h47, 8'h41};
      base = strobe_cyc.size();
      idle(10);
      for (int i = 0; i < 5; i++) send_byte(msg[i], CPB, 1'b1, c[i]);
      idle(10);
      n_cmp++; if (strobe_cyc.size() !== base + 5) begin n_bad++; $display("[TB] FAIL b2b_count: got %0d expected 5", strobe_cyc.size() - base); end
      for (int i = 0; i < 5; i++) begin
         if (strobe_cyc.size() > base + i && strobe_len.size() > base + i) begin
            n_cmp++; if (strobe_data[base+i] !== msg[i]) begin n_bad++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, strobe_data[base+i], msg[i]); end
            n_cmp++; if (strobe_cyc[base+i] !== c[i] + 155) begin n_bad++; $display("[TB] FAIL b2b_rise%0d: got cycle %0d expected %0d", i, strobe_cyc[base+i], c[i] + 155); end
            n_cmp++; if (strobe_len[base+i] !== VC) begin n_bad++; $display("[TB] FAIL b2b_len%0d: got %0d expected %0d", i, strobe_len[base+i], VC); end
            if (i > 0) begin
               n_cmp++; if (strobe_cyc[base+i] - strobe_cyc[base+i-1] !== 160) begin n_bad++; $display("[TB] FAIL b2b_gap%0d: got %0d expected 160", i, strobe_cyc[base+i] - strobe_cyc[base+i-1]); end
            end
         end
      end
      n_cmp++; if (data !== 8'h41) begin n_bad++; $display("[TB] FAIL b2b_last_data: got %h expected 41", data); end
   endtask

   task automatic test_glitch;
      int base;
      base = strobe_cyc.size();
      idle(10);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (7) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL glitch_busy_before_check: got %b expected 1", busy); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL glitch_busy_after_check: got %b expected 0", busy); end
      idle(30);
      n_cmp++; if (strobe_cyc.size() !== base) begin n_bad++; $display("[TB] FAIL glitch_strobe: got %0d strobes expected 0", strobe_cyc.size() - base); end
      n_cmp++; if (data !== 8'h41) begin n_bad++; $display("[TB] FAIL glitch_data: got %h expected 41", data); end
   endtask

   task automatic test_framing_break;
      int base;
      int c0;
      base = strobe_cyc.size();
      idle(10);
      send_byte(8'h55, CPB, 1'b0, c0);
      repeat (100) @(negedge clk);
      n_cmp++; if (framing_error !== 1'b1) begin n_bad++; $display("[TB] FAIL break_ferr: got %b expected 1", framing_error); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL break_busy_low: got %b expected 1", busy); end
      n_cmp++; if (data !== 8'h41) begin n_bad++; $display("[TB] FAIL break_data: got %h expected 41", data); end
      n_cmp++; if (strobe_cyc.size() !== base) begin n_bad++; $display("[TB] FAIL break_strobe: got %0d strobes expected 0", strobe_cyc.size() - base); end
      rx = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL break_busy_sync: got %b expected 1", busy); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL break_busy_release: got %b expected 0", busy); end
      n_cmp++; if (framing_error !== 1'b1) begin n_bad++; $display("[TB] FAIL break_ferr_sticky: got %b expected 1", framing_error); end
      idle(10);
      send_byte(8'h0D, CPB, 1'b1, c0);
      idle(10);
      n_cmp++; if (strobe_cyc.size() !== base + 1) begin n_bad++; $display("[TB] FAIL recover_count: got %0d expected 1", strobe_cyc.size() - base); end
      n_cmp++; if (data !== 8'h0D) begin n_bad++; $display("[TB] FAIL recover_data: got %h expected 0d", data); end
      n_cmp++; if (framing_error !== 1'b0) begin n_bad++; $display("[TB] FAIL recover_ferr: got %b expected 0", framing_error); end
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] b;
      int base;
      int c0;
      b = 8'hA5;
      base = strobe_cyc.size();
      idle(10);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = b[3];
      repeat (8) @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (data !== 8'h00) begin n_bad++; $display("[TB] FAIL midrst_data: got %h expected 00", data); end
      n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_valid: got %b expected 0", data_valid); end
      n_cmp++; if (framing_error !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_ferr: got %b expected 0", framing_error); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
      repeat (6) @(negedge clk);
      rx = b[4];
      repeat (CPB) @(negedge clk);
      rx = b[5];
      repeat (CPB) @(negedge clk);
      rx = b[6];
      repeat (14) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      rx = b[7];
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
      idle(40);
      n_cmp++; if (strobe_cyc.size() !== base) begin n_bad++; $display("[TB] FAIL midrst_strobe: got %0d strobes expected 0", strobe_cyc.size() - base); end
      n_cmp++; if (data !== 8'h00) begin n_bad++; $display("[TB] FAIL midrst_after_data: got %h expected 00", data); end
      n_cmp++; if (framing_error !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_after_ferr: got %b expected 0", framing_error); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_after_busy: got %b expected 0", busy); end
      send_byte(8'h3A, CPB, 1'b1, c0);
      idle(10);
      n_cmp++; if (strobe_cyc.size() !== base + 1) begin n_bad++; $display("[TB] FAIL midrst_next_count: got %0d expected 1", strobe_cyc.size() - base); end
      n_cmp++; if (data !== 8'h3A) begin n_bad++; $display("[TB] FAIL midrst_next_data: got %h expected 3a", data); end
      n_cmp++; if (framing_error !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_next_ferr: got %b expected 0", framing_error); end
   endtask

   task automatic test_baud_tolerance;
      int rates [2];
      int base;
      int c0;
      rates = '{15, 17};
      for (int r = 0; r < 2; r++) begin
         base = strobe_cyc.size();
         idle(20);
         send_byte(8'hC3, rates[r], 1'b1, c0);
         idle(20);
         n_cmp++; if (strobe_cyc.size() !== base + 1) begin n_bad++; $display("[TB] FAIL baud%0d_count: got %0d expected 1", rates[r], strobe_cyc.size() - base); end
         n_cmp++; if (data !== 8'hC3) begin n_bad++; $display("[TB] FAIL baud%0d_data: got %h expected c3", rates[r], data); end
         n_cmp++; if (framing_error !== 1'b0) begin n_bad++; $display("[TB] FAIL baud%0d_ferr: got %b expected 0", rates[r], framing_error); end
      end
   endtask

   // Scenarios run in order; each leaves the line idle high.
   initial begin
      $display("[TB] gps_uart_rx directed bench start");
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_glitch();
      test_framing_break();
      test_reset_mid_frame();
      test_baud_tolerance();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
